// File: rtl/mcu_link_pkg.sv
// ---------------------------------------------------------------------------
// mcu_link_pkg
// Shared definitions for the FPGA->MCU config link transmitter:
//   - tx_state_e      : transmit FSM states
//   - PERSIST_HDR_DEFAULT : header byte that opens every persist message
//   - CMD_LEN / PERSIST_LEN : message lengths in bytes
//   - byte_period()   : minimum dot4x cycles between consecutive strobe rises
// ---------------------------------------------------------------------------
package mcu_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STROBE,
        GUARD,
        WAITBUSY
    } tx_state_e;

    localparam logic [7:0] PERSIST_HDR_DEFAULT = 8'h50;

    localparam int CMD_LEN     = 1;
    localparam int PERSIST_LEN = 3;

    // One LOAD cycle, the strobe, the CDC guard and at least one WAITBUSY cycle.
    function automatic int byte_period(input int strobe_cycles, input int guard_cycles);
        return 1 + strobe_cycles + guard_cycles + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO backed by an inferred RAM with a registered read port.
// pop_data is updated on the edge that performs the pop and then holds until
// the next pop, so the consumer can use it as a message register.
// The caller must not push when full (unless also popping) nor pop when empty.
//
// Ports:
//   clk_dot4x  in   clock
//   rst        in   synchronous active-high reset (pointers and count only)
//   push       in   write push_data at the write pointer
//   push_data  in   WIDTH-bit entry
//   pop        in   read head entry into pop_data, advance read pointer
//   pop_data   out  registered head entry
//   full       out  count == DEPTH
//   empty      out  count == 0
//   count      out  number of stored entries (log2(DEPTH)+1 bits)
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk_dot4x,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] pop_data_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;

    // Storage and read port carry no reset so they map onto block RAM.
    // When full with a simultaneous push and pop both pointers are equal; the
    // non-blocking read returns the old head before it is overwritten.
    always_ff @(posedge clk_dot4x) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
        if (pop) begin
            pop_data_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign pop_data = pop_data_reg;
    assign count    = count_reg;
    assign full     = (count_reg == (AW + 1)'(DEPTH));
    assign empty    = (count_reg == '0);

endmodule

// File: rtl/mcu_tx_scheduler.sv
// ---------------------------------------------------------------------------
// mcu_tx_scheduler
// Sequences every byte sent on the FPGA->MCU config link. Two requesters:
// register-persist writes (3-byte messages: header, addr, data, queued in a
// FIFO) and single-byte MCU commands (one-deep latch). A message is always
// sent to completion before the next is selected; commands win arbitration,
// which only happens in IDLE. Each byte is strobed, then a guard interval lets
// the strobe cross out and tx_busy_4x cross back before busy is trusted.
//
// Ports:
//   clk_dot4x       in   dot4x clock (only clock)
//   rst             in   synchronous active-high reset
//   persist_req     in   pulse: enqueue {persist_addr, persist_data}
//   persist_addr    in   register address to persist
//   persist_data    in   register value to persist
//   cmd_req         in   pulse: send cmd_byte
//   cmd_byte        in   command byte
//   tx_busy_4x      in   MCU busy, already synchronised
//   tx_data_4x      out  byte on the link, stable while strobe is high
//   tx_new_data_4x  out  byte strobe
//   fifo_full       out  persist FIFO holds DEPTH entries
//   cmd_pending     out  command latched, not yet strobed
//   overflow        out  sticky: a request was dropped
//   idle            out  FSM idle, FIFO empty, no command pending
// ---------------------------------------------------------------------------
module mcu_tx_scheduler
    import mcu_link_pkg::*;
#(
    parameter int         DEPTH         = 4,
    parameter int         STROBE_CYCLES = 2,
    parameter int         GUARD_CYCLES  = 6,
    parameter logic [7:0] PERSIST_HDR   = PERSIST_HDR_DEFAULT
) (
    input  logic       clk_dot4x,
    input  logic       rst,
    input  logic       persist_req,
    input  logic [7:0] persist_addr,
    input  logic [7:0] persist_data,
    input  logic       cmd_req,
    input  logic [7:0] cmd_byte,
    input  logic       tx_busy_4x,
    output logic [7:0] tx_data_4x,
    output logic       tx_new_data_4x,
    output logic       fifo_full,
    output logic       cmd_pending,
    output logic       overflow,
    output logic       idle
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(STROBE_CYCLES + GUARD_CYCLES + 1);

    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    tx_state_e        state_reg;
    logic [1:0]       byte_idx_reg;
    logic [1:0]       msg_len_reg;
    logic             is_cmd_reg;
    logic [CNT_W-1:0] cyc_cnt_reg;
    logic [7:0]       tx_data_reg;
    logic             tx_strobe_reg;
    logic [7:0]       cmd_byte_reg;
    logic             cmd_pending_reg;
    logic             overflow_reg;

    // ------------------------------------------------------------------
    // Persist FIFO
    // ------------------------------------------------------------------
    logic          fifo_push;
    logic          fifo_pop;
    logic [15:0]   fifo_rd_data;
    logic          fifo_full_w;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;

    // The head is popped in IDLE only when no command is waiting; the popped
    // entry then sits in the FIFO's read register for the whole message.
    assign fifo_pop  = (state_reg == IDLE) && !cmd_pending_reg && !fifo_empty;
    // A full FIFO still accepts an entry on the cycle it frees a slot.
    assign fifo_push = persist_req && (!fifo_full_w || fifo_pop);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_persist_fifo (
        .clk_dot4x (clk_dot4x),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({persist_addr, persist_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full_w),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ------------------------------------------------------------------
    // Request acceptance
    // ------------------------------------------------------------------
    logic persist_drop;
    logic cmd_accept;
    logic cmd_drop;

    assign persist_drop = persist_req && !fifo_push;
    assign cmd_accept   = cmd_req && !cmd_pending_reg;
    assign cmd_drop     = cmd_req && cmd_pending_reg;

    // ------------------------------------------------------------------
    // Byte selection: header followed by the address and data halves of
    // the popped entry (high byte first).
    // ------------------------------------------------------------------
    logic [7:0] persist_bytes [PERSIST_LEN];
    logic [7:0] cur_byte;

    assign persist_bytes[0] = PERSIST_HDR;

    genvar gi;
    generate
        for (gi = 1; gi < PERSIST_LEN; gi++) begin : g_persist_body
            assign persist_bytes[gi] = fifo_rd_data[(PERSIST_LEN - 1 - gi) * 8 +: 8];
        end
    endgenerate

    always_comb begin
        cur_byte = persist_bytes[byte_idx_reg];
        if (is_cmd_reg) begin
            cur_byte = cmd_byte_reg;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            state_reg       <= IDLE;
            byte_idx_reg    <= '0;
            msg_len_reg     <= '0;
            is_cmd_reg      <= 1'b0;
            cyc_cnt_reg     <= '0;
            tx_data_reg     <= '0;
            tx_strobe_reg   <= 1'b0;
            cmd_byte_reg    <= '0;
            cmd_pending_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            if (persist_drop || cmd_drop) begin
                overflow_reg <= 1'b1;
            end

            // A command cannot be accepted while the previous one is pending,
            // so the set and the clear never coincide.
            if (cmd_accept) begin
                cmd_pending_reg <= 1'b1;
                cmd_byte_reg    <= cmd_byte;
            end else if (state_reg == LOAD && is_cmd_reg) begin
                cmd_pending_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    byte_idx_reg <= '0;
                    if (cmd_pending_reg) begin
                        is_cmd_reg  <= 1'b1;
                        msg_len_reg <= 2'(CMD_LEN);
                        state_reg   <= LOAD;
                    end else if (!fifo_empty) begin
                        is_cmd_reg  <= 1'b0;
                        msg_len_reg <= 2'(PERSIST_LEN);
                        state_reg   <= LOAD;
                    end
                end

                LOAD: begin
                    tx_data_reg   <= cur_byte;
                    tx_strobe_reg <= 1'b1;
                    cyc_cnt_reg   <= '0;
                    state_reg     <= STROBE;
                end

                STROBE: begin
                    if (cyc_cnt_reg == STROBE_LAST) begin
                        tx_strobe_reg <= 1'b0;
                        cyc_cnt_reg   <= '0;
                        state_reg     <= GUARD;
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
                    end
                end

                // Busy is stale until the strobe has crossed out and the
                // MCU's response has crossed back.
                GUARD: begin
                    if (cyc_cnt_reg == GUARD_LAST) begin
                        cyc_cnt_reg <= '0;
                        state_reg   <= WAITBUSY;
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
                    end
                end

                WAITBUSY: begin
                    if (!tx_busy_4x) begin
                        if (byte_idx_reg == msg_len_reg - 2'd1) begin
                            state_reg <= IDLE;
                        end else begin
                            byte_idx_reg <= byte_idx_reg + 2'd1;
                            state_reg    <= LOAD;
                        end
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx_data_4x     = tx_data_reg;
    assign tx_new_data_4x = tx_strobe_reg;
    assign fifo_full      = fifo_full_w;
    assign cmd_pending    = cmd_pending_reg;
    assign overflow       = overflow_reg;
    assign idle           = (state_reg == IDLE) && (fifo_count == '0) && !cmd_pending_reg;

endmodule

// File: tb/tb_mcu_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mcu_tx_scheduler
// Directed stimulus pushes the bytes it expects on the wire into exp_q; an
// independent monitor pops one entry per strobe rise and compares. Strobe
// rise cycles are logged so the stimulus side can check latency and pacing.
// ---------------------------------------------------------------------------
module tb_mcu_tx_scheduler;
    import mcu_link_pkg::*;

    localparam int BYTE_PERIOD = byte_period(2, 6);   // 10 cycles per byte
    localparam int MSG_GAP     = BYTE_PERIOD + 1;     // extra IDLE cycle between messages

    logic       clk_dot4x = 1'b0;
    logic       rst = 1'b1;
    logic       persist_req = 1'b0;
    logic [7:0] persist_addr = '0;
    logic [7:0] persist_data = '0;
    logic       cmd_req = 1'b0;
    logic [7:0] cmd_byte = '0;
    logic       tx_busy_4x = 1'b0;
    logic [7:0] tx_data_4x;
    logic       tx_new_data_4x;
    logic       fifo_full;
    logic       cmd_pending;
    logic       overflow;
    logic       idle;

    always #5 clk_dot4x = ~clk_dot4x;

    mcu_tx_scheduler #(
        .DEPTH         (4),
        .STROBE_CYCLES (2),
        .GUARD_CYCLES  (6),
        .PERSIST_HDR   (8'h50)
    ) dut (
        .clk_dot4x      (clk_dot4x),
        .rst            (rst),
        .persist_req    (persist_req),
        .persist_addr   (persist_addr),
        .persist_data   (persist_data),
        .cmd_req        (cmd_req),
        .cmd_byte       (cmd_byte),
        .tx_busy_4x     (tx_busy_4x),
        .tx_data_4x     (tx_data_4x),
        .tx_new_data_4x (tx_new_data_4x),
        .fifo_full      (fifo_full),
        .cmd_pending    (cmd_pending),
        .overflow       (overflow),
        .idle           (idle)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         rise_q[$];
    int         req_edge;
    int         fall_edge;
    bit         watch_busy = 1'b0;
    int         busy_viol = 0;
    logic       mon_prev = 1'b0;
    int         mon_width = 0;
    logic [7:0] mon_held = '0;

    always @(posedge clk_dot4x) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk_dot4x);
            #1;
            if (rst) begin
                mon_prev  = 1'b0;
                mon_width = 0;
            end else begin
                if (watch_busy && tx_new_data_4x && tx_busy_4x) busy_viol++;
                if (tx_new_data_4x && !mon_prev) begin
                    rise_q.push_back(cyc);
                    mon_width = 1;
                    mon_held  = tx_data_4x;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected no byte (cycle %0d)", tx_data_4x, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("wire_byte", {24'd0, tx_data_4x}, {24'd0, e});
                        $display("byte 0x%02h at cycle %0d", tx_data_4x, cyc);
                    end
                end else if (tx_new_data_4x && mon_prev) begin
                    mon_width++;
                    check("data_stable", {24'd0, tx_data_4x}, {24'd0, mon_held});
                end else if (!tx_new_data_4x && mon_prev) begin
                    check("strobe_width", mon_width, 2);
                end
                mon_prev = tx_new_data_4x;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_dot4x);
    endtask

    task automatic pulse_persist(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk_dot4x);
        persist_req  = 1'b1;
        persist_addr = a;
        persist_data = d;
        req_edge     = cyc + 1;
        @(negedge clk_dot4x);
        persist_req  = 1'b0;
    endtask

    task automatic pulse_cmd(input logic [7:0] c);
        @(negedge clk_dot4x);
        cmd_req  = 1'b1;
        cmd_byte = c;
        req_edge = cyc + 1;
        @(negedge clk_dot4x);
        cmd_req  = 1'b0;
    endtask

    task automatic wait_rises(input int n);
        int t = 0;
        while (rise_q.size() < n && t < 600) begin
            @(negedge clk_dot4x);
            t++;
        end
        if (rise_q.size() < n) check("rise_timeout", rise_q.size(), n);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(idle && exp_q.size() == 0) && t < 1000) begin
            @(negedge clk_dot4x);
            t++;
        end
        check("idle_after_traffic", {31'd0, idle}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_data"},     {24'd0, tx_data_4x}, 32'd0);
        check({tag, "_strobe"},      {31'd0, tx_new_data_4x}, 32'd0);
        check({tag, "_fifo_full"},   {31'd0, fifo_full}, 32'd0);
        check({tag, "_cmd_pending"}, {31'd0, cmd_pending}, 32'd0);
        check({tag, "_overflow"},    {31'd0, overflow}, 32'd0);
        check({tag, "_idle"},        {31'd0, idle}, 32'd1);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(2);

        // 1: single persist message, busy low
        rise_q.delete();
        exp_q.push_back(8'h50); exp_q.push_back(8'h3F); exp_q.push_back(8'hA5);
        pulse_persist(8'h3F, 8'hA5);
        wait_rises(3);
        if (rise_q.size() >= 3) begin
            check("t1_latency", rise_q[0] - req_edge, 2);
            check("t1_gap01", rise_q[1] - rise_q[0], BYTE_PERIOD);
            check("t1_gap12", rise_q[2] - rise_q[1], BYTE_PERIOD);
        end
        wait_idle();

        // 2: command during the address byte waits for the message end
        rise_q.delete();
        exp_q.push_back(8'h50); exp_q.push_back(8'hAA); exp_q.push_back(8'hDD);
        pulse_persist(8'hAA, 8'hDD);
        wait_rises(2);
        exp_q.push_back(8'hC1);
        pulse_cmd(8'hC1);
        check("t2_cmd_pending", {31'd0, cmd_pending}, 32'd1);
        wait_rises(4);
        if (rise_q.size() >= 4) check("t2_cmd_after_msg", rise_q[3] - rise_q[2], MSG_GAP);
        wait_idle();

        // 3: simultaneous cmd and persist from IDLE, command first
        rise_q.delete();
        exp_q.push_back(8'hC1);
        exp_q.push_back(8'h50); exp_q.push_back(8'h12); exp_q.push_back(8'h34);
        @(negedge clk_dot4x);
        cmd_req = 1'b1; cmd_byte = 8'hC1;
        persist_req = 1'b1; persist_addr = 8'h12; persist_data = 8'h34;
        req_edge = cyc + 1;
        @(negedge clk_dot4x);
        cmd_req = 1'b0; persist_req = 1'b0;
        wait_rises(4);
        if (rise_q.size() >= 4) begin
            check("t3_cmd_latency", rise_q[0] - req_edge, 2);
            check("t3_msg_gap", rise_q[1] - rise_q[0], MSG_GAP);
        end
        check("t3_overflow", {31'd0, overflow}, 32'd0);
        wait_idle();

        // 4: FIFO fill and overflow while the link is stalled behind a command
        rise_q.delete();
        tx_busy_4x = 1'b1;
        exp_q.push_back(8'h11);
        pulse_cmd(8'h11);
        wait_rises(1);
        tick(3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_dot4x);
            if (i == 4) begin
                check("t4_full_after_4", {31'd0, fifo_full}, 32'd1);
                check("t4_no_ovf_after_4", {31'd0, overflow}, 32'd0);
            end
            persist_req  = 1'b1;
            persist_addr = 8'(i + 1);
            persist_data = 8'((i + 1) * 16);
            if (i < 4) begin
                exp_q.push_back(8'h50);
                exp_q.push_back(8'(i + 1));
                exp_q.push_back(8'((i + 1) * 16));
            end
        end
        @(negedge clk_dot4x);
        persist_req = 1'b0;
        check("t4_ovf_after_5", {31'd0, overflow}, 32'd1);
        check("t4_still_full", {31'd0, fifo_full}, 32'd1);
        tick(5);
        check("t4_stalled", rise_q.size(), 1);
        tx_busy_4x = 1'b0;
        wait_rises(13);
        wait_idle();
        check("t4_byte_count", rise_q.size(), 13);
        rst = 1'b1;
        tick(2);
        check("t4_ovf_cleared", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        tick(2);

        // 5: busy pulse after a strobe holds off the next byte
        rise_q.delete();
        busy_viol = 0;
        exp_q.push_back(8'h50); exp_q.push_back(8'h5A); exp_q.push_back(8'hA5);
        pulse_persist(8'h5A, 8'hA5);
        wait_rises(1);
        tick(3);
        tx_busy_4x = 1'b1;
        watch_busy = 1'b1;
        tick(20);
        tx_busy_4x = 1'b0;
        fall_edge  = cyc + 1;
        wait_rises(2);
        watch_busy = 1'b0;
        if (rise_q.size() >= 2) check("t5_resume", rise_q[1] - fall_edge, 1);
        check("t5_no_strobe_while_busy", busy_viol, 0);
        wait_rises(3);
        if (rise_q.size() >= 3) check("t5_gap12", rise_q[2] - rise_q[1], BYTE_PERIOD);
        wait_idle();

        // 6: reset during the header's guard abandons the message and queue
        rise_q.delete();
        exp_q.push_back(8'h50); exp_q.push_back(8'h77); exp_q.push_back(8'h88);
        pulse_persist(8'h77, 8'h88);
        pulse_persist(8'h66, 8'h99);
        wait_rises(1);
        tick(3);
        check("t6_pre_reset_data", {24'd0, tx_data_4x}, 32'h50);
        rst = 1'b1;
        @(negedge clk_dot4x);
        check_reset_outputs("t6_reset");
        exp_q.delete();
        rst = 1'b0;
        tick(2);
        rise_q.delete();
        exp_q.push_back(8'h50); exp_q.push_back(8'h9A); exp_q.push_back(8'hBC);
        pulse_persist(8'h9A, 8'hBC);
        wait_rises(3);
        if (rise_q.size() >= 1) check("t6_restart_latency", rise_q[0] - req_edge, 2);
        wait_idle();
        tick(30);
        check("t6_no_stale_bytes", rise_q.size(), 3);

        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mcu_tx_scheduler.md
Name: mcu_tx_scheduler

Overview:
- Sequences all outbound traffic on the FPGA→MCU config link, i.e. the tx_data_4x / tx_new_data_4x / tx_busy_4x handshake that the top level crosses into the sys_clock domain.
- Arbitrates between two requesters:
  - register-persist writes, framed as 3-byte messages and buffered in a small FIFO;
  - single-byte MCU commands.
- Never interleaves bytes of different messages.
- Paces every byte so the 2-flop CDC in both directions is always satisfied.
- Sits inside vicii, between the register file and the tx_*_4x ports.

Parameters:
- DEPTH, 4, persist FIFO entries; must be a power of 2, minimum 2.
- STROBE_CYCLES, 2, dot4x cycles tx_new_data_4x is held high per byte.
- GUARD_CYCLES, 6, dot4x cycles after strobe fall before tx_busy_4x is trusted; covers 2-flop sync out plus 2-flop sync back.
- PERSIST_HDR, 8'h50, header byte opening each persist message.

Ports:
- clk_dot4x  in  1  system 4x dot clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- persist_req  in  1  one-cycle pulse: enqueue {persist_addr, persist_data}.
- persist_addr  in  8  register address to persist.
- persist_data  in  8  register value to persist.
- cmd_req  in  1  one-cycle pulse: send cmd_byte.
- cmd_byte  in  8  command byte.
- tx_busy_4x  in  1  MCU link busy, already synchronised to clk_dot4x.
- tx_data_4x  out  8  byte presented to the link.
- tx_new_data_4x  out  1  strobe; byte is valid while high.
- fifo_full  out  1  persist FIFO holds DEPTH entries.
- cmd_pending  out  1  command latched and not yet sent.
- overflow  out  1  sticky; a request was dropped.
- idle  out  1  FSM in IDLE, FIFO empty, no command pending.

Behaviour:
- Reset values: tx_data_4x=0, tx_new_data_4x=0, fifo_full=0, cmd_pending=0, overflow=0, idle=1. FIFO pointers and count are cleared.
- Reset mid-message abandons the message; the MCU resynchronises on the next header.
- Persist enqueue:
  - When persist_req=1 and count<DEPTH, write {addr,data} at wr_ptr on the same edge.
  - When persist_req=1 and count==DEPTH, drop the request and set overflow.
  - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Command latch:
  - When cmd_req=1 and cmd_pending=0, latch cmd_byte and set cmd_pending.
  - When cmd_req=1 and cmd_pending=1, drop the request, set overflow, keep the old byte.
- Simultaneous events:
  - persist_req and cmd_req in the same cycle are both accepted.
  - An enqueue and a dequeue in the same cycle leave count unchanged; a full FIFO accepts the new entry.
- Arbitration happens only in IDLE, and command has fixed priority:
  - If cmd_pending: send 1 byte (cmd); clear cmd_pending on entering STROBE.
  - Else if FIFO non-empty: pop the head into a message register and send 3 bytes: PERSIST_HDR, addr, data.
- FSM states:
  - IDLE: select a message per the arbitration rule, go to LOAD.
  - LOAD: drive tx_data_4x = current byte, go to STROBE.
  - STROBE: tx_new_data_4x=1 for STROBE_CYCLES cycles; tx_data_4x is stable throughout. Then go to GUARD.
  - GUARD: counter runs GUARD_CYCLES, then go to WAITBUSY.
  - WAITBUSY: stay while tx_busy_4x=1. When low, go to LOAD if bytes remain, else IDLE.
- Latency: a request arriving in IDLE with nothing ahead of it gives its first strobe rise 2 cycles after the request edge.
- Minimum per-byte period is 1+STROBE_CYCLES+GUARD_CYCLES+1 cycles.
- tx_data_4x holds its last value outside STROBE and never changes while the strobe is high.
- A command arriving mid-persist-message waits for the message end; it is never inserted between header and data.
- tx_busy_4x stuck high stalls in WAITBUSY indefinitely. Requests keep queueing and overflow behaves normally.

Decomposition:
- Shared package (mcu_link_pkg):
  - state enum {IDLE, LOAD, STROBE, GUARD, WAITBUSY};
  - PERSIST_HDR default;
  - message-length constants (CMD_LEN=1, PERSIST_LEN=3);
  - per-byte period function.
- Sub-module sync_fifo (DEPTH × 16 bits, push/pop/full/empty/count), instantiated once.
- The FSM, byte-index counter and cycle counter stay in mcu_tx_scheduler.

Test Plan:
- Persist pulse addr=8'h3F data=8'hA5, tx_busy_4x held 0 → bytes 50,3F,A5 each strobed exactly 2 cycles. Strobe rises are 10 cycles apart; idle=1 after the last byte.
- 5 persist pulses back-to-back with tx_busy_4x=1 → fifo_full after the 4th, overflow=1 after the 5th. Releasing busy sends exactly 4 messages in order.
- cmd_req 8'hC1 issued during byte 2 of a persist message → C1 appears only after the data byte's WAITBUSY exit. Order on the wire: 50,aa,dd,C1.
- cmd_req and persist_req in the same cycle from IDLE → C1 sent first, then the persist message; overflow=0.
- tx_busy_4x pulsed high for 20 cycles starting 3 cycles after a strobe → next LOAD occurs no earlier than the busy fall plus 1 cycle. No strobe while busy=1.
- rst asserted during GUARD of a persist header → next cycle all outputs at reset values and FIFO empty. A new request then restarts cleanly with the header byte.
